ex_mem_reg: RTL and testbench

EX_MEM_REG -- requirements
Module: ex_mem_reg

---
 rtl/ex_mem_reg.sv | 167 ++++++++++++++++
 tb/tb_ex_mem_reg.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with a one-entry skid buffer.
// It provides a valid/ready handshake on both sides, a synchronous flush and a branch redirect.
package ex_mem_reg_pkg;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              branch;
    logic              mem_read;
    logic              mem_write;
    logic              zero;
    logic [DATA_W-1:0] alu_add_result;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] read_data2;
    logic [REG_W-1:0]  write_reg;
  } ex_mem_t;
endpackage

module ex_mem_reg
  import ex_mem_reg_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  input  logic              Branch_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              Zero_in,
  input  logic [DATA_W-1:0] ALUAddResult_in,
  input  logic [DATA_W-1:0] ALUResult_in,
  input  logic [DATA_W-1:0] ReadData2_in,
  input  logic [REG_W-1:0]  WriteReg_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              RegWrite_out,
  output logic              MemtoReg_out,
  output logic              Branch_out,
  output logic              MemRead_out,
  output logic              MemWrite_out,
  output logic              Zero_out,
  output logic [DATA_W-1:0] ALUAddResult_out,
  output logic [DATA_W-1:0] ALUResult_out,
  output logic [DATA_W-1:0] ReadData2_out,
  output logic [REG_W-1:0]  WriteReg_out,
  output logic              PCSrc,
  output logic [DATA_W-1:0] BranchTarget
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e  state_q, state_d;
  ex_mem_t main_q, main_d;
  ex_mem_t skid_q, skid_d;
  logic    in_ready_q, in_ready_d;
  logic    out_valid_q, out_valid_d;
  ex_mem_t in_entry;
  logic    in_fire;

  // Clearing side-effecting controls when main empties keeps bubbles harmless with registered outputs.
  function automatic ex_mem_t kill_ctrl(input ex_mem_t e);
    ex_mem_t r;
    r           = e;
    r.reg_write = 1'b0;
    r.branch    = 1'b0;
    r.mem_read  = 1'b0;
    r.mem_write = 1'b0;
    return r;
  endfunction

  always_comb begin
    in_entry                = '0;
    in_entry.reg_write      = RegWrite_in;
    in_entry.mem_to_reg     = MemtoReg_in;
    in_entry.branch         = Branch_in;
    in_entry.mem_read       = MemRead_in;
    in_entry.mem_write      = MemWrite_in;
    in_entry.zero           = Zero_in;
    in_entry.alu_add_result = ALUAddResult_in;
    in_entry.alu_result     = ALUResult_in;
    in_entry.read_data2     = ReadData2_in;
    in_entry.write_reg      = WriteReg_in;
  end

  assign in_fire = in_valid & in_ready_q;

  // Next-state and entry movement; flush overrides every transfer.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          main_d  = in_entry;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (in_fire && out_ready) begin
          main_d = in_entry;
        end else if (in_fire) begin
          skid_d  = in_entry;
          state_d = S_TWO;
        end else if (out_ready) begin
          main_d  = kill_ctrl(main_q);
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (out_ready) begin
          main_d  = skid_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (Flush) begin
      main_d  = kill_ctrl(main_q);
      skid_d  = kill_ctrl(skid_q);
      state_d = S_EMPTY;
    end
    in_ready_d  = (state_d != S_TWO);
    out_valid_d = (state_d != S_EMPTY);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready         = in_ready_q;
  assign out_valid        = out_valid_q;
  assign RegWrite_out     = main_q.reg_write;
  assign MemtoReg_out     = main_q.mem_to_reg;
  assign Branch_out       = main_q.branch;
  assign MemRead_out      = main_q.mem_read;
  assign MemWrite_out     = main_q.mem_write;
  assign Zero_out         = main_q.zero;
  assign ALUAddResult_out = main_q.alu_add_result;
  assign ALUResult_out    = main_q.alu_result;
  assign ReadData2_out    = main_q.read_data2;
  assign WriteReg_out     = main_q.write_reg;
  assign PCSrc            = out_valid_q & main_q.branch & main_q.zero;
  assign BranchTarget     = main_q.alu_add_result;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: streaming, backpressure, branch, flush and reset.
module tb_ex_mem_reg;
  logic        Clk = 1'b0;
  logic        Reset, Flush, in_valid, in_ready, out_valid, out_ready;
  logic        RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in, Zero_in;
  logic [31:0] ALUAddResult_in, ALUResult_in, ReadData2_in;
  logic [4:0]  WriteReg_in;
  logic        RegWrite_out, MemtoReg_out, Branch_out, MemRead_out, MemWrite_out, Zero_out;
  logic [31:0] ALUAddResult_out, ALUResult_out, ReadData2_out;
  logic [4:0]  WriteReg_out;
  logic        PCSrc;
  logic [31:0] BranchTarget;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  ex_mem_reg dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .Branch_in(Branch_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .Zero_in(Zero_in),
    .ALUAddResult_in(ALUAddResult_in), .ALUResult_in(ALUResult_in),
    .ReadData2_in(ReadData2_in), .WriteReg_in(WriteReg_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out), .Branch_out(Branch_out),
    .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out), .Zero_out(Zero_out),
    .ALUAddResult_out(ALUAddResult_out), .ALUResult_out(ALUResult_out),
    .ReadData2_out(ReadData2_out), .WriteReg_out(WriteReg_out),
    .PCSrc(PCSrc), .BranchTarget(BranchTarget)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b1; Flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    RegWrite_in = 1'b0; MemtoReg_in = 1'b0; Branch_in = 1'b0;
    MemRead_in = 1'b0; MemWrite_in = 1'b0; Zero_in = 1'b0;
    ALUAddResult_in = 32'h0; ALUResult_in = 32'h0; ReadData2_in = 32'h0; WriteReg_in = 5'd0;
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_pcsrc", 32'(PCSrc), 32'd0);
    check("rst_alu", ALUResult_out, 32'd0);
    Reset = 1'b0;

    // Streaming with one-cycle latency
    out_ready = 1'b1; in_valid = 1'b1; RegWrite_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      ALUResult_in = 32'(i);
      step();
      check("stream_alu", ALUResult_out, 32'(i));
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_in_ready", 32'(in_ready), 32'd1);
      check("stream_regwrite", 32'(RegWrite_out), 32'd1);
    end
    in_valid = 1'b0; RegWrite_in = 1'b0;
    step();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("bubble_regwrite", 32'(RegWrite_out), 32'd0);
    check("bubble_data_hold", ALUResult_out, 32'd8);

    // Backpressure into the skid entry
    out_ready = 1'b0; in_valid = 1'b1; ALUResult_in = 32'h10;
    step();
    check("bp_one_alu", ALUResult_out, 32'h10);
    check("bp_one_in_ready", 32'(in_ready), 32'd1);
    ALUResult_in = 32'h20;
    step();
    check("bp_two_alu", ALUResult_out, 32'h10);
    check("bp_two_in_ready", 32'(in_ready), 32'd0);
    ALUResult_in = 32'h99;
    step();
    check("bp_hold_alu", ALUResult_out, 32'h10);
    check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("bp_second_alu", ALUResult_out, 32'h20);
    check("bp_second_valid", 32'(out_valid), 32'd1);
    check("bp_in_ready_back", 32'(in_ready), 32'd1);
    step();
    check("bp_empty_valid", 32'(out_valid), 32'd0);
    check("bp_no_dup_alu", ALUResult_out, 32'h20);

    // Branch redirect
    in_valid = 1'b1; Branch_in = 1'b1; Zero_in = 1'b1; ALUAddResult_in = 32'h40;
    step();
    check("br_taken_pcsrc", 32'(PCSrc), 32'd1);
    check("br_target", BranchTarget, 32'h40);
    Zero_in = 1'b0;
    step();
    check("br_not_taken_pcsrc", 32'(PCSrc), 32'd0);
    check("br_branch_out", 32'(Branch_out), 32'd1);
    in_valid = 1'b0; Branch_in = 1'b0;
    step();
    check("br_bubble_branch", 32'(Branch_out), 32'd0);
    check("br_bubble_pcsrc", 32'(PCSrc), 32'd0);

    // Flush while holding two entries
    out_ready = 1'b0; in_valid = 1'b1; RegWrite_in = 1'b1; MemWrite_in = 1'b1;
    ALUResult_in = 32'hA1;
    step();
    ALUResult_in = 32'hA2;
    step();
    check("fl_two_in_ready", 32'(in_ready), 32'd0);
    Flush = 1'b1; ALUResult_in = 32'hA3;
    step();
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_regwrite", 32'(RegWrite_out), 32'd0);
    check("fl_memwrite", 32'(MemWrite_out), 32'd0);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    Flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; RegWrite_in = 1'b0; MemWrite_in = 1'b0;
    step();
    check("fl_stays_empty", 32'(out_valid), 32'd0);
    in_valid = 1'b1; ALUResult_in = 32'hB0;
    step();
    check("fl_next_entry", ALUResult_out, 32'hB0);
    // Flush overrides an acceptable input in ONE
    Flush = 1'b1; ALUResult_in = 32'hC0;
    step();
    check("fl_one_valid", 32'(out_valid), 32'd0);
    Flush = 1'b0; in_valid = 1'b0;
    step();
    check("fl_one_dropped", 32'(out_valid), 32'd0);
    check("fl_one_data", ALUResult_out, 32'hB0);

    // Reset (with simultaneous flush) while holding a store
    out_ready = 1'b0; in_valid = 1'b1; MemWrite_in = 1'b1; Branch_in = 1'b1; Zero_in = 1'b1;
    ALUResult_in = 32'h55; ALUAddResult_in = 32'h77; ReadData2_in = 32'h33; WriteReg_in = 5'd7;
    step();
    check("pre_rst_memwrite", 32'(MemWrite_out), 32'd1);
    check("pre_rst_pcsrc", 32'(PCSrc), 32'd1);
    check("pre_rst_wreg", 32'(WriteReg_out), 32'd7);
    Reset = 1'b1; Flush = 1'b1;
    step();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_memwrite", 32'(MemWrite_out), 32'd0);
    check("mid_rst_alu", ALUResult_out, 32'd0);
    check("mid_rst_add", ALUAddResult_out, 32'd0);
    check("mid_rst_rd2", ReadData2_out, 32'd0);
    check("mid_rst_wreg", 32'(WriteReg_out), 32'd0);
    check("mid_rst_pcsrc", 32'(PCSrc), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    Reset = 1'b0; Flush = 1'b0; MemWrite_in = 1'b0; Branch_in = 1'b0; Zero_in = 1'b0;
    ALUResult_in = 32'h66;
    step();
    check("post_rst_accept", ALUResult_out, 32'h66);
    check("post_rst_valid", 32'(out_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
